// File: rtl/valu_resp_buffer_pkg.sv
// ---------------------------------------------------------------------------
// valu_resp_buffer_pkg
// Purpose : Shared constants and types for the vALU response buffer slice.
//           Holds the result/address widths, the worst-case vALU latency
//           that bounds the buffer depth, the packed FIFO entry layout and
//           the credit-counter operation encoding.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package valu_resp_buffer_pkg;

   localparam int RESP_DATA_WIDTH  = 64;
   localparam int ADDR_WIDTH       = 5;
   localparam int VALU_MAX_LATENCY = 4;
   localparam int DEFAULT_DEPTH    = 8;

   // One buffered result: destination address above the result data.
   typedef struct packed {
      logic [ADDR_WIDTH-1:0]      addr;
      logic [RESP_DATA_WIDTH-1:0] vec;
   } resp_entry_t;

   // What the credit counter does on the next clock edge.
   typedef enum logic [1:0] {
      CREDIT_HOLD   = 2'd0,
      CREDIT_TAKE   = 2'd1,
      CREDIT_RETURN = 2'd2
   } credit_op_e;

   // True when n is a power of two and at least 2, which keeps the FIFO
   // pointers wrapping naturally at their bit width.
   function automatic bit isPow2AtLeast2(input int n);
      return (n >= 2) && ((n & (n - 1)) == 0);
   endfunction

endpackage

// File: rtl/valu_resp_buffer_if.sv
// ---------------------------------------------------------------------------
// valu_resp_buffer_if
// Purpose : Bundles the issue handshake, the fixed-latency result strobe,
//           the writeback valid/ready handshake and the sticky error flag.
// Signals : issue_valid/issue_ready  issue-stage credit handshake
//           in_vec/in_addr/in_valid  vALU result, one per cycle, no stall
//           out_vec/out_addr         head entry toward the VRF write port
//           out_valid/out_ready      writeback handshake
//           err_overflow             sticky result-dropped indication
// Modports: slave  - the response buffer itself
//           master - the surrounding pipeline / testbench
// ---------------------------------------------------------------------------
interface valu_resp_buffer_if;
   import valu_resp_buffer_pkg::*;

   logic                       issue_valid;
   logic                       issue_ready;
   logic [RESP_DATA_WIDTH-1:0] in_vec;
   logic [ADDR_WIDTH-1:0]      in_addr;
   logic                       in_valid;
   logic [RESP_DATA_WIDTH-1:0] out_vec;
   logic [ADDR_WIDTH-1:0]      out_addr;
   logic                       out_valid;
   logic                       out_ready;
   logic                       err_overflow;

   modport slave (
      input  issue_valid,
      output issue_ready,
      input  in_vec,
      input  in_addr,
      input  in_valid,
      output out_vec,
      output out_addr,
      output out_valid,
      input  out_ready,
      output err_overflow
   );

   modport master (
      output issue_valid,
      input  issue_ready,
      output in_vec,
      output in_addr,
      output in_valid,
      input  out_vec,
      input  out_addr,
      input  out_valid,
      output out_ready,
      input  err_overflow
   );

endinterface

// File: rtl/valu_resp_buffer_vfifo_sync.sv
// ---------------------------------------------------------------------------
// vfifo_sync
// Purpose : First-word fall-through synchronous FIFO. The head entry is
//           visible combinationally from the storage array, so data written
//           on edge N is presented after that edge with no extra register.
// Ports   : clk               sole clock
//           rst               synchronous active-high reset (empties FIFO)
//           i_push/i_pushData write request and data
//           i_pop             consume the head entry (ignored when empty)
//           o_popData         head entry (don't-care when empty)
//           o_count           number of stored entries
//           o_full/o_empty    occupancy flags derived from the count
//           o_pushWhileFull   push request that had to be dropped
// ---------------------------------------------------------------------------
module vfifo_sync #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_push,
   input  logic [WIDTH-1:0]             i_pushData,
   input  logic                         i_pop,
   output logic [WIDTH-1:0]             o_popData,
   output logic [$clog2(DEPTH+1)-1:0]   o_count,
   output logic                         o_full,
   output logic                         o_empty,
   output logic                         o_pushWhileFull
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_rdPtr;
   logic [PTR_W-1:0] r_wrPtr;
   logic [CNT_W-1:0] r_count;

   logic w_popFire;
   logic w_pushFire;

   // Occupancy comes from the count, not pointer comparison. A push into a
   // full FIFO is still accepted when the head leaves the same cycle, since
   // the slot being written is the one being freed.
   always_comb begin
      o_count         = r_count;
      o_full          = (r_count == CNT_W'(DEPTH));
      o_empty         = (r_count == '0);
      o_popData       = r_mem[r_rdPtr];
      w_popFire       = i_pop & ~o_empty;
      w_pushFire      = i_push & (~o_full | w_popFire);
      o_pushWhileFull = i_push & o_full & ~w_popFire;
   end

   // Storage has no reset; only written entries are ever presented. Writes
   // are suppressed while reset is asserted so a result arriving during
   // reset never lands in the array.
   always_ff @(posedge clk) begin
      if (!rst && w_pushFire) begin
         r_mem[r_wrPtr] <= i_pushData;
      end
   end

   // Pointers wrap at their bit width because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rdPtr <= '0;
         r_wrPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_pushFire) begin
            r_wrPtr <= r_wrPtr + PTR_W'(1);
         end
         if (w_popFire) begin
            r_rdPtr <= r_rdPtr + PTR_W'(1);
         end
         case ({w_pushFire, w_popFire})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/valu_resp_buffer.sv
// ---------------------------------------------------------------------------
// valu_resp_buffer
// Purpose : Consumer end of the vALU fixed-latency result path. Results
//           cannot be stalled, so every issued op reserves a FIFO slot via
//           a credit counter before it may launch; the FIFO then feeds
//           vector-register writeback with a valid/ready handshake in
//           strict arrival order.
// Ports   : clk   sole clock, all state updates on posedge
//           rst   synchronous active-high reset; drops entries, restores
//                 all credits and clears the sticky error
//           bus   valu_resp_buffer_if.slave (issue, result, writeback and
//                 err_overflow signals)
// ---------------------------------------------------------------------------
module valu_resp_buffer
   import valu_resp_buffer_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic               clk,
   input  logic               rst,
   valu_resp_buffer_if.slave  bus
);

   localparam int CNT_W   = $clog2(DEPTH + 1);
   localparam int ENTRY_W = RESP_DATA_WIDTH + ADDR_WIDTH;

   // A depth smaller than the pipeline latency plus one could see a result
   // arrive with nowhere to go; a non power-of-two depth breaks pointer wrap.
   if (DEPTH < VALU_MAX_LATENCY + 1) begin : g_depthTooSmall
      $error("valu_resp_buffer: DEPTH must be >= VALU_MAX_LATENCY + 1");
   end
   if (!isPow2AtLeast2(DEPTH)) begin : g_depthNotPow2
      $error("valu_resp_buffer: DEPTH must be a power of two and >= 2");
   end

   logic [CNT_W-1:0] r_credits;
   logic             r_errOverflow;
   credit_op_e       w_creditOp;

   resp_entry_t      w_pushEntry;
   resp_entry_t      w_headEntry;
   logic [CNT_W-1:0] w_count;
   logic             w_full;
   logic             w_empty;
   logic             w_pushWhileFull;
   logic             w_issueFire;
   logic             w_deq;
   logic             w_unusedStatus;

   // The FIFO stores address and data together so they can never drift apart.
   assign w_pushEntry = '{addr: bus.in_addr, vec: bus.in_vec};

   vfifo_sync #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk             (clk),
      .rst             (rst),
      .i_push          (bus.in_valid),
      .i_pushData      (w_pushEntry),
      .i_pop           (bus.out_ready),
      .o_popData       (w_headEntry),
      .o_count         (w_count),
      .o_full          (w_full),
      .o_empty         (w_empty),
      .o_pushWhileFull (w_pushWhileFull)
   );

   // Count and full are provided by the FIFO for other users; this block
   // only needs the empty flag to drive writeback.
   assign w_unusedStatus = ^{w_count, w_full};

   // Writeback view of the head entry and the issue handshake. issue_ready
   // is purely a function of the credit register so it has no path from
   // issue_valid.
   always_comb begin
      bus.out_vec      = w_headEntry.vec;
      bus.out_addr     = w_headEntry.addr;
      bus.out_valid    = ~w_empty;
      bus.issue_ready  = (r_credits != '0);
      bus.err_overflow = r_errOverflow;
      w_issueFire      = bus.issue_valid & bus.issue_ready;
      w_deq            = bus.out_valid & bus.out_ready;
   end

   // A fire and a dequeue in the same cycle cancel: the freed slot is handed
   // straight to the new reservation. Returns are clamped at DEPTH so stray
   // results that were never reserved cannot mint extra credits.
   always_comb begin
      w_creditOp = CREDIT_HOLD;
      if (w_issueFire && !w_deq) begin
         w_creditOp = CREDIT_TAKE;
      end else if (w_deq && !w_issueFire && (r_credits != CNT_W'(DEPTH))) begin
         w_creditOp = CREDIT_RETURN;
      end
   end

   // Credit register: starts with every slot available.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_credits <= CNT_W'(DEPTH);
      end else begin
         case (w_creditOp)
            CREDIT_TAKE:   r_credits <= r_credits - CNT_W'(1);
            CREDIT_RETURN: r_credits <= r_credits + CNT_W'(1);
            default:       r_credits <= r_credits;
         endcase
      end
   end

   // Sticky overflow flag: once a result has been lost it stays visible
   // until reset, since the lost data cannot be recovered.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_errOverflow <= 1'b0;
      end else if (w_pushWhileFull) begin
         r_errOverflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_valu_resp_buffer.sv
// ---------------------------------------------------------------------------
// tb_valu_resp_buffer
// Purpose : Directed scenarios followed by random traffic against a
//           queue-based reference of the response buffer: an ordered list
//           of stored results, an integer credit count and an error flag.
// ---------------------------------------------------------------------------
module tb_valu_resp_buffer;
   import valu_resp_buffer_pkg::*;

   localparam int DEPTH = 8;

   logic clk = 1'b0;
   logic rst;

   valu_resp_buffer_if vif();

   valu_resp_buffer #(.DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (vif.slave)
   );

   always #5 clk = ~clk;

   resp_entry_t modelQ[$];
   int          modelCredits;
   bit          modelOvf;
   int          checks   = 0;
   int          failures = 0;

   // One comparison of a DUT value against the reference value.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Compare every visible output against the reference state.
   task automatic checkAll(input string step);
      checkOutput({step, ":out_valid"}, 64'(vif.out_valid), 64'(modelQ.size() != 0));
      checkOutput({step, ":issue_ready"}, 64'(vif.issue_ready), 64'(modelCredits != 0));
      checkOutput({step, ":err_overflow"}, 64'(vif.err_overflow), 64'(modelOvf));
      if (modelQ.size() != 0) begin
         checkOutput({step, ":out_vec"}, vif.out_vec, modelQ[0].vec);
         checkOutput({step, ":out_addr"}, 64'(vif.out_addr), 64'(modelQ[0].addr));
      end
   endtask

   // Drive one cycle of inputs, advance the reference by the same cycle,
   // then compare just after the clock edge.
   task automatic applyStimulus(input string step, input bit issueV, input bit inV,
                                input logic [63:0] v, input logic [4:0] a,
                                input bit outR, input bit rstV);
      bit fire;
      bit deq;
      rst             = rstV;
      vif.issue_valid = issueV;
      vif.in_valid    = inV;
      vif.in_vec      = v;
      vif.in_addr     = a;
      vif.out_ready   = outR;
      if (rstV) begin
         modelQ.delete();
         modelCredits = DEPTH;
         modelOvf     = 1'b0;
      end else begin
         fire = issueV && (modelCredits > 0);
         deq  = outR && (modelQ.size() > 0);
         if (deq) void'(modelQ.pop_front());
         if (inV) begin
            if (modelQ.size() >= DEPTH) modelOvf = 1'b1;
            else modelQ.push_back(resp_entry_t'{addr: a, vec: v});
         end
         modelCredits = modelCredits - int'(fire) + int'(deq);
         if (modelCredits > DEPTH) modelCredits = DEPTH;
      end
      @(posedge clk);
      #1;
      checkAll(step);
   endtask

   function automatic logic [63:0] rand64();
      return {$urandom(), $urandom()};
   endfunction

   initial begin
      rst             = 1'b1;
      vif.issue_valid = 1'b0;
      vif.in_valid    = 1'b0;
      vif.in_vec      = '0;
      vif.in_addr     = '0;
      vif.out_ready   = 1'b0;

      $display("[TB] reset");
      applyStimulus("reset", 0, 0, 0, 0, 0, 1);
      applyStimulus("reset", 0, 0, 0, 0, 0, 1);
      applyStimulus("post_reset", 0, 0, 0, 0, 0, 0);

      $display("[TB] issue until credits exhausted");
      for (int i = 0; i < DEPTH; i++) applyStimulus("t1_issue", 1, 0, 0, 0, 0, 0);
      checkOutput("t1_ready_after_8", 64'(vif.issue_ready), 64'd0);
      applyStimulus("t1_ninth", 1, 0, 0, 0, 0, 0);
      checkOutput("t1_ninth_blocked", 64'(vif.issue_ready), 64'd0);

      $display("[TB] single result");
      applyStimulus("t2_push", 0, 1, 64'hDEAD_BEEF_0123_4567, 5'd3, 0, 0);
      checkOutput("t2_vec", vif.out_vec, 64'hDEAD_BEEF_0123_4567);
      checkOutput("t2_addr", 64'(vif.out_addr), 64'd3);
      applyStimulus("t2_pop", 0, 0, 0, 0, 1, 0);
      checkOutput("t2_valid_cleared", 64'(vif.out_valid), 64'd0);
      checkOutput("t2_credit_back", 64'(vif.issue_ready), 64'd1);

      $display("[TB] back-to-back stream with toggling out_ready");
      for (int i = 0; i < DEPTH; i++) applyStimulus("t3_stream", 0, 1, 64'(i), 5'(i), i[0], 0);
      for (int i = 0; i < DEPTH; i++) applyStimulus("t3_drain", 0, 0, 0, 0, 1, 0);

      $display("[TB] push and pop while full");
      applyStimulus("t4_reset", 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < DEPTH; i++) applyStimulus("t4_fill", 1, 1, rand64(), 5'($urandom_range(31)), 0, 0);
      applyStimulus("t4_pushpop", 0, 1, rand64(), 5'($urandom_range(31)), 1, 0);
      checkOutput("t4_no_error", 64'(vif.err_overflow), 64'd0);
      for (int i = 0; i <= DEPTH; i++) applyStimulus("t4_drain", 0, 0, 0, 0, 1, 0);

      $display("[TB] overflow");
      for (int i = 0; i < DEPTH; i++) applyStimulus("t5_fill", 0, 1, rand64(), 5'($urandom_range(31)), 0, 0);
      applyStimulus("t5_overflow", 0, 1, 64'hBAD0_BAD0_BAD0_BAD0, 5'd31, 0, 0);
      checkOutput("t5_err_set", 64'(vif.err_overflow), 64'd1);
      for (int i = 0; i <= DEPTH; i++) applyStimulus("t5_drain", 0, 0, 0, 0, 1, 0);
      applyStimulus("t5_reset", 0, 1, rand64(), 5'd1, 0, 1);
      checkOutput("t5_err_cleared", 64'(vif.err_overflow), 64'd0);
      checkOutput("t5_empty_after_reset", 64'(vif.out_valid), 64'd0);

      $display("[TB] issue and dequeue at zero credits");
      applyStimulus("t6_reset_release", 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < DEPTH; i++) applyStimulus("t6_issue", 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < DEPTH; i++) applyStimulus("t6_results", 0, 1, rand64(), 5'(i), 0, 0);
      for (int i = 0; i < 3; i++) applyStimulus("t6_issue_deq", 1, 0, 0, 0, 1, 0);

      $display("[TB] random traffic");
      for (int i = 0; i < 400; i++) begin
         applyStimulus("rand", 1'($urandom_range(1)), 1'($urandom_range(1)), rand64(),
                       5'($urandom_range(31)), ($urandom_range(3) != 0),
                       ($urandom_range(63) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
